chacha_round_engine: RTL

Iterative ChaCha block-function core that turns a 256-bit key, 96-bit nonce and 32-bit block counter into one 512-bit keystream block. It is the sequential successor of the combinational quarter-round datapath: round count and quarter-rounds-per-cycle are parameters, and it adds a start/ready input handshake, an output valid/ready handshake and the final feed-forward addition. It sits between the key/nonce management logic and the keystream XOR stage of the card-data cipher path.

---
 rtl/chacha_pkg.sv | 48 ++++
 rtl/chacha_qr.sv | 27 ++
 rtl/chacha_round_engine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and index tables for the iterative ChaCha block core.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  localparam word_t CONST_WORDS [4] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  localparam logic [3:0] COL_TBL [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_TBL [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [3:0] qr_index(input logic diag, input logic [1:0] grp,
                                          input logic [1:0] pos);
    return diag ? DIAG_TBL[grp][pos] : COL_TBL[grp][pos];
  endfunction

  // Word 15 sits in the top 32 bits, so the concatenation mirrors the state layout.
  function automatic state_t init_state(input logic [255:0] key, input word_t counter,
                                        input logic [95:0] nonce);
    return {nonce, counter, key, CONST_WORDS[3], CONST_WORDS[2], CONST_WORDS[1],
            CONST_WORDS[0]};
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round (add/xor/rotate by 16, 12, 8, 7).
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t qa,
  output word_t qb,
  output word_t qc,
  output word_t qd
);

  word_t a1, b1, c1, d1;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);

  assign qa = a1 + b1;
  assign qd = rotl(d1 ^ qa, 8);
  assign qc = c1 + qd;
  assign qb = rotl(b1 ^ qc, 7);

endmodule

// File: rtl/chacha_round_engine.sv
// Iterative ChaCha block function: start/ready input handshake, QR_PER_CYCLE quarter
// rounds per cycle, feed-forward add, and a valid/ready handshake on the keystream.
module chacha_round_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output fsm_state_e   dbg_state
);

  // Handshake: an input block is accepted on an edge where start && ready; a result is
  // consumed on an edge where out_valid && out_ready. Both ready and out_valid are registered.

  localparam int STEPS = 4 / QR_PER_CYCLE;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int HW    = $clog2(2 * ROUNDS);

  if ((ROUNDS % 2) != 0 || ROUNDS < 2 || ROUNDS > 20) begin : g_bad_rounds
    $error("chacha_round_engine: ROUNDS must be even and within 2..20");
  end
  if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qr
    $error("chacha_round_engine: QR_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_state_e     state;
  state_t         work;
  state_t         work_next;
  state_t         saved_state;
  state_t         final_sum;
  logic [255:0]   key_q;
  word_t          counter_q;
  logic [95:0]    nonce_q;
  logic [SW-1:0]  step_cnt;
  logic [HW-1:0]  hr_cnt;
  logic [3:0]     idx    [QR_PER_CYCLE][4];
  word_t          qr_in  [QR_PER_CYCLE][4];
  word_t          qr_out [QR_PER_CYCLE][4];

  assign dbg_state   = state;
  assign saved_state = init_state(key_q, counter_q, nonce_q);

  // Even half-rounds are column rounds, odd ones diagonal; step selects the group slice.
  always_comb begin
    for (int u = 0; u < QR_PER_CYCLE; u++) begin
      for (int k = 0; k < 4; k++) begin
        idx[u][k] = qr_index(hr_cnt[0], 2'(int'(step_cnt) * QR_PER_CYCLE + u), 2'(k));
      end
    end
  end

  always_comb begin
    for (int u = 0; u < QR_PER_CYCLE; u++) begin
      for (int k = 0; k < 4; k++) begin
        qr_in[u][k] = work[idx[u][k]];
      end
    end
  end

  for (genvar u = 0; u < QR_PER_CYCLE; u++) begin : g_qr
    chacha_qr u_qr (
      .a  (qr_in[u][0]),
      .b  (qr_in[u][1]),
      .c  (qr_in[u][2]),
      .d  (qr_in[u][3]),
      .qa (qr_out[u][0]),
      .qb (qr_out[u][1]),
      .qc (qr_out[u][2]),
      .qd (qr_out[u][3])
    );
  end

  // Groups within one half-round touch disjoint words, so parallel write-back is safe.
  always_comb begin
    work_next = work;
    for (int u = 0; u < QR_PER_CYCLE; u++) begin
      for (int k = 0; k < 4; k++) begin
        work_next[idx[u][k]] = qr_out[u][k];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sum
    assign final_sum[i] = work[i] + saved_state[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      keystream <= '0;
      work      <= '0;
      key_q     <= '0;
      counter_q <= '0;
      nonce_q   <= '0;
      step_cnt  <= '0;
      hr_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work      <= init_state(key, counter, nonce);
            key_q     <= key;
            counter_q <= counter;
            nonce_q   <= nonce;
            step_cnt  <= '0;
            hr_cnt    <= '0;
            ready     <= 1'b0;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work <= work_next;
          if (step_cnt == SW'(STEPS - 1)) begin
            step_cnt <= '0;
            if (hr_cnt == HW'(ROUNDS - 1)) begin
              hr_cnt <= '0;
              state  <= ST_FINAL;
            end else begin
              hr_cnt <= hr_cnt + HW'(1);
            end
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end
        ST_FINAL: begin
          keystream <= final_sum;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle raises out_valid; it then holds until the consumer takes it.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            ready     <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
